// File: rtl/core_control_ldst_bus_pkg.sv
// Shared types for the load/store bus responder: word/pointer types,
// FSM state encoding and the request record held in the latched and pending slots.
package core_control_ldst_bus_pkg;

    typedef logic [29:0] ptr;
    typedef logic [31:0] word;

    typedef enum logic [1:0] {
        MEM_IDLE  = 2'd0,
        MEM_CMD   = 2'd1,
        MEM_RDATA = 2'd2
    } ctrl_mem_state;

    typedef struct packed {
        ptr   addr;
        logic write;
        word  data;
    } mem_req;

    localparam logic [3:0] AVL_BE_ALL = 4'b1111;

    function automatic logic [31:0] byte_addr(input ptr addr);
        return {addr, 2'b00};
    endfunction

endpackage

// File: rtl/core_control_ldst_bus_timeout.sv
// Per-transaction cycle counter; expired flags the cycle on whose closing edge
// the count reaches LIMIT.
module core_control_ldst_bus_timeout #(
    parameter int unsigned LIMIT = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + W'(1);
        end
    end

    assign expired = enable && (count == W'(LIMIT - 1));

endmodule

// File: rtl/core_control_ldst_bus.sv
// Load/store sequencer to Avalon-MM pipelined master bridge with a one-entry pending slot.
// Optional transaction timeout is built in when CORE_MEM_TIMEOUT_EN is defined.
//
// state | meaning
// IDLE  | no transaction on the bus; accepts pending or new request
// CMD   | avl_read/avl_write held until waitrequest is low
// RDATA | read accepted, waiting for readdatavalid
module core_control_ldst_bus
    import core_control_ldst_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_start,
    input  ptr          mem_addr,
    input  logic        mem_write,
    input  word         mem_data_wr,
    output logic        mem_ready,
    output word         mem_data_rd,
    output logic        mem_fault,
    output logic        mem_overrun,
    output logic [31:0] avl_address,
    output logic        avl_read,
    output logic        avl_write,
    output logic [31:0] avl_writedata,
    output logic [3:0]  avl_byteenable,
    input  logic        avl_waitrequest,
    input  logic [31:0] avl_readdata,
    input  logic        avl_readdatavalid
);

    localparam logic [1:0] IDLE  = MEM_IDLE;
    localparam logic [1:0] CMD   = MEM_CMD;
    localparam logic [1:0] RDATA = MEM_RDATA;

    logic [1:0] state;
    mem_req     pend;
    logic       pend_valid;
    mem_req     new_req;
    mem_req     launch_req;
    logic       launch;
    logic       cmd_accept;
    logic       wr_done;
    logic       rd_take;
    logic       rd_done;
    logic       abort;

    always_comb begin
        new_req    = '{addr: mem_addr, write: mem_write, data: mem_data_wr};
        launch_req = pend_valid ? pend : new_req;
    end

    assign launch     = (state == IDLE) && (pend_valid || mem_start);
    assign cmd_accept = (state == CMD) && (avl_read || avl_write) && !avl_waitrequest;
    assign wr_done    = cmd_accept && avl_write;
    assign rd_done    = (state == RDATA) && rd_take;

    assign avl_byteenable = AVL_BE_ALL;

`ifdef CORE_MEM_TIMEOUT_EN
    logic expired;
    logic stale;

    core_control_ldst_bus_timeout #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (launch),
        .enable (state != IDLE),
        .expired(expired)
    );

    // A completion landing on the expiry edge wins over the abort.
    assign abort   = expired && !wr_done && !rd_done;
    assign rd_take = avl_readdatavalid && !stale;

    // Reads abandoned after the slave took them still owe one beat; swallow it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stale     <= 1'b0;
            mem_fault <= 1'b0;
        end else begin
            mem_fault <= abort;
            if (abort && ((state == RDATA) || (cmd_accept && avl_read))) begin
                stale <= 1'b1;
            end else if (avl_readdatavalid) begin
                stale <= 1'b0;
            end
        end
    end
`else
    logic unused_timeout;

    assign abort          = 1'b0;
    assign rd_take        = avl_readdatavalid;
    assign mem_fault      = 1'b0;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            pend          <= '0;
            pend_valid    <= 1'b0;
            mem_ready     <= 1'b0;
            mem_overrun   <= 1'b0;
            mem_data_rd   <= '0;
            avl_address   <= '0;
            avl_read      <= 1'b0;
            avl_write     <= 1'b0;
            avl_writedata <= '0;
        end else begin
            mem_ready <= 1'b0;
            if (abort) begin
                state     <= IDLE;
                avl_read  <= 1'b0;
                avl_write <= 1'b0;
                mem_ready <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (launch) begin
                            state         <= CMD;
                            avl_address   <= byte_addr(launch_req.addr);
                            avl_writedata <= launch_req.data;
                            avl_read      <= !launch_req.write;
                            avl_write     <= launch_req.write;
                        end
                    end
                    CMD: begin
                        if (cmd_accept) begin
                            avl_read  <= 1'b0;
                            avl_write <= 1'b0;
                            if (avl_write) begin
                                state     <= IDLE;
                                mem_ready <= 1'b1;
                            end else begin
                                state <= RDATA;
                            end
                        end
                    end
                    RDATA: begin
                        if (rd_take) begin
                            mem_data_rd <= avl_readdata;
                            mem_ready   <= 1'b1;
                            state       <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end

            // In IDLE the pending entry is promoted this cycle, so it is free for a new start.
            if (state == IDLE) begin
                if (pend_valid) begin
                    pend_valid <= mem_start;
                    if (mem_start) begin
                        pend <= new_req;
                    end
                end
            end else if (mem_start) begin
                if (!pend_valid) begin
                    pend_valid <= 1'b1;
                    pend       <= new_req;
                end else begin
                    mem_overrun <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_core_control_ldst_bus.sv
// Directed bench for core_control_ldst_bus; the timeout scenario runs only
// when CORE_MEM_TIMEOUT_EN is defined (DUT built with TIMEOUT_CYCLES = 8).
module tb_core_control_ldst_bus;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        mem_start = 1'b0;
    logic [29:0] mem_addr = '0;
    logic        mem_write = 1'b0;
    logic [31:0] mem_data_wr = '0;
    logic        mem_ready;
    logic [31:0] mem_data_rd;
    logic        mem_fault;
    logic        mem_overrun;
    logic [31:0] avl_address;
    logic        avl_read;
    logic        avl_write;
    logic [31:0] avl_writedata;
    logic [3:0]  avl_byteenable;
    logic        avl_waitrequest = 1'b0;
    logic [31:0] avl_readdata = '0;
    logic        avl_readdatavalid = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    core_control_ldst_bus #(.TIMEOUT_CYCLES(8)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .mem_start        (mem_start),
        .mem_addr         (mem_addr),
        .mem_write        (mem_write),
        .mem_data_wr      (mem_data_wr),
        .mem_ready        (mem_ready),
        .mem_data_rd      (mem_data_rd),
        .mem_fault        (mem_fault),
        .mem_overrun      (mem_overrun),
        .avl_address      (avl_address),
        .avl_read         (avl_read),
        .avl_write        (avl_write),
        .avl_writedata    (avl_writedata),
        .avl_byteenable   (avl_byteenable),
        .avl_waitrequest  (avl_waitrequest),
        .avl_readdata     (avl_readdata),
        .avl_readdatavalid(avl_readdatavalid)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic wr, input logic [29:0] a, input logic [31:0] d);
        mem_start   = 1'b1;
        mem_write   = wr;
        mem_addr    = a;
        mem_data_wr = d;
    endtask

    task automatic test_reset;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        tick;
        tick;
        n_cmp++; if ({mem_ready, mem_fault, mem_overrun, avl_read, avl_write} !== 5'b0) begin n_err++; $display("FAIL reset_flags: got %b want 00000", {mem_ready, mem_fault, mem_overrun, avl_read, avl_write}); end
        n_cmp++; if (avl_address !== 32'h0) begin n_err++; $display("FAIL reset_addr: got %h want 0", avl_address); end
        n_cmp++; if (avl_writedata !== 32'h0) begin n_err++; $display("FAIL reset_wdata: got %h want 0", avl_writedata); end
        n_cmp++; if (mem_data_rd !== 32'h0) begin n_err++; $display("FAIL reset_rdata: got %h want 0", mem_data_rd); end
        n_cmp++; if (avl_byteenable !== 4'hF) begin n_err++; $display("FAIL byteenable: got %h want f", avl_byteenable); end
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_store;
        issue(1'b1, 30'h100, 32'hDEADBEEF);
        tick;
        mem_start = 1'b0;
        n_cmp++; if ({avl_write, avl_read, mem_ready} !== 3'b100) begin n_err++; $display("FAIL store_c1_strobes: got %b want 100", {avl_write, avl_read, mem_ready}); end
        n_cmp++; if (avl_address !== 32'h400) begin n_err++; $display("FAIL store_addr: got %h want 400", avl_address); end
        n_cmp++; if (avl_writedata !== 32'hDEADBEEF) begin n_err++; $display("FAIL store_wdata: got %h want deadbeef", avl_writedata); end
        tick;
        n_cmp++; if ({mem_ready, mem_fault, avl_write} !== 3'b100) begin n_err++; $display("FAIL store_c2_ready: got %b want 100", {mem_ready, mem_fault, avl_write}); end
        tick;
        n_cmp++; if (mem_ready !== 1'b0) begin n_err++; $display("FAIL store_c3_pulse: got %b want 0", mem_ready); end
    endtask

    task automatic test_load_wait;
        int rd_cycles;
        int ready_cnt;
        int ready_cycle;
        logic [31:0] data_at_ready;
        rd_cycles = 0; ready_cnt = 0; ready_cycle = -1; data_at_ready = '0;
        issue(1'b0, 30'h4, 32'h0);
        tick;
        mem_start = 1'b0;
        n_cmp++; if (avl_address !== 32'h10) begin n_err++; $display("FAIL load_addr: got %h want 10", avl_address); end
        for (int c = 1; c <= 9; c++) begin
            avl_waitrequest   = (c <= 3);
            avl_readdatavalid = (c == 6);
            avl_readdata      = (c == 6) ? 32'h12345678 : 32'hFFFF0000;
            if (avl_read) rd_cycles++;
            if (mem_ready) begin ready_cnt++; ready_cycle = c; data_at_ready = mem_data_rd; end
            tick;
        end
        avl_waitrequest = 1'b0; avl_readdatavalid = 1'b0;
        n_cmp++; if (rd_cycles !== 4) begin n_err++; $display("FAIL load_read_held: got %0d want 4", rd_cycles); end
        n_cmp++; if (ready_cycle !== 7 || ready_cnt !== 1) begin n_err++; $display("FAIL load_ready_cycle: got %0d (count %0d) want 7 (count 1)", ready_cycle, ready_cnt); end
        n_cmp++; if (data_at_ready !== 32'h12345678) begin n_err++; $display("FAIL load_data: got %h want 12345678", data_at_ready); end
        issue(1'b1, 30'h8, 32'h0);
        tick;
        mem_start = 1'b0;
        tick;
        n_cmp++; if (mem_ready !== 1'b1 || mem_data_rd !== 32'h12345678) begin n_err++; $display("FAIL load_data_hold: got ready %b data %h want 1 12345678", mem_ready, mem_data_rd); end
        tick;
    endtask

    task automatic test_pending;
        int rdy1;
        int rdy2;
        int wr_first;
        logic [31:0] wr_addr;
        logic [31:0] wr_data;
        rdy1 = -1; rdy2 = -1; wr_first = -1; wr_addr = '0; wr_data = '0;
        issue(1'b0, 30'h20, 32'h0);
        tick;
        for (int c = 1; c <= 6; c++) begin
            if (c == 1) issue(1'b1, 30'h21, 32'hCAFEF00D);
            else mem_start = 1'b0;
            avl_readdatavalid = (c == 2);
            avl_readdata      = 32'h55AA55AA;
            if (mem_ready) begin
                if (rdy1 < 0) rdy1 = c;
                else rdy2 = c;
            end
            if (avl_write && wr_first < 0) begin wr_first = c; wr_addr = avl_address; wr_data = avl_writedata; end
            tick;
        end
        avl_readdatavalid = 1'b0;
        n_cmp++; if (rdy1 !== 3) begin n_err++; $display("FAIL pend_load_ready: got %0d want 3", rdy1); end
        n_cmp++; if (wr_first !== 4) begin n_err++; $display("FAIL pend_write_cycle: got %0d want 4", wr_first); end
        n_cmp++; if (rdy2 !== 5) begin n_err++; $display("FAIL pend_store_ready: got %0d want 5", rdy2); end
        n_cmp++; if (wr_addr !== 32'h84 || wr_data !== 32'hCAFEF00D) begin n_err++; $display("FAIL pend_store_cmd: got %h/%h want 84/cafef00d", wr_addr, wr_data); end
        n_cmp++; if (mem_data_rd !== 32'h55AA55AA) begin n_err++; $display("FAIL pend_load_data: got %h want 55aa55aa", mem_data_rd); end
        n_cmp++; if (mem_overrun !== 1'b0) begin n_err++; $display("FAIL pend_no_overrun: got %b want 0", mem_overrun); end
    endtask

    task automatic test_back_to_back;
        issue(1'b1, 30'h50, 32'hA);
        tick;
        mem_start = 1'b0;
        tick;
        n_cmp++; if (mem_ready !== 1'b1) begin n_err++; $display("FAIL b2b_first_ready: got %b want 1", mem_ready); end
        issue(1'b1, 30'h51, 32'hB);
        tick;
        mem_start = 1'b0;
        n_cmp++; if (avl_write !== 1'b1 || avl_address !== 32'h144) begin n_err++; $display("FAIL b2b_second_cmd: got %b/%h want 1/144", avl_write, avl_address); end
        tick;
        n_cmp++; if (mem_ready !== 1'b1) begin n_err++; $display("FAIL b2b_second_ready: got %b want 1", mem_ready); end
        tick;
        avl_readdatavalid = 1'b1; avl_readdata = 32'h0BADF00D;
        tick;
        avl_readdatavalid = 1'b0;
        n_cmp++; if (mem_ready !== 1'b0 || mem_data_rd !== 32'h55AA55AA) begin n_err++; $display("FAIL stray_rdv: got ready %b data %h want 0 55aa55aa", mem_ready, mem_data_rd); end
        tick;
    endtask

`ifdef CORE_MEM_TIMEOUT_EN
    task automatic test_timeout;
        int rdy1;
        int rdy2;
        int nrdy;
        logic f1;
        logic f2;
        logic [31:0] d1;
        logic [31:0] d2;
        rdy1 = -1; rdy2 = -1; nrdy = 0; f1 = 1'b0; f2 = 1'b1; d1 = '0; d2 = '0;
        issue(1'b0, 30'h30, 32'h0);
        tick;
        mem_start = 1'b0;
        for (int c = 1; c <= 15; c++) begin
            if (c == 10) issue(1'b0, 30'h31, 32'h0);
            else mem_start = 1'b0;
            avl_readdatavalid = (c == 12 || c == 13);
            avl_readdata      = (c == 12) ? 32'hBAD : 32'h600D;
            if (mem_ready) begin
                nrdy++;
                if (rdy1 < 0) begin rdy1 = c; f1 = mem_fault; d1 = mem_data_rd; end
                else begin rdy2 = c; f2 = mem_fault; d2 = mem_data_rd; end
            end
            tick;
        end
        avl_readdatavalid = 1'b0;
        n_cmp++; if (rdy1 !== 9 || f1 !== 1'b1) begin n_err++; $display("FAIL timeout_abort: got cycle %0d fault %b want 9 1", rdy1, f1); end
        n_cmp++; if (d1 !== 32'h55AA55AA) begin n_err++; $display("FAIL timeout_rdata_kept: got %h want 55aa55aa", d1); end
        n_cmp++; if (rdy2 !== 14 || f2 !== 1'b0 || d2 !== 32'h600D) begin n_err++; $display("FAIL stale_discard: got cycle %0d fault %b data %h want 14 0 600d", rdy2, f2, d2); end
        n_cmp++; if (nrdy !== 2) begin n_err++; $display("FAIL timeout_ready_count: got %0d want 2", nrdy); end
    endtask
`endif

    task automatic test_overrun;
        int nrdy;
        logic seen_b;
        logic seen_c;
        nrdy = 0; seen_b = 1'b0; seen_c = 1'b0;
        avl_waitrequest = 1'b1;
        issue(1'b1, 30'h40, 32'h1);
        tick;
        issue(1'b1, 30'h41, 32'h2);
        tick;
        n_cmp++; if (mem_overrun !== 1'b0) begin n_err++; $display("FAIL overrun_early: got %b want 0", mem_overrun); end
        issue(1'b1, 30'h42, 32'h3);
        tick;
        mem_start = 1'b0;
        n_cmp++; if (mem_overrun !== 1'b1) begin n_err++; $display("FAIL overrun_set: got %b want 1", mem_overrun); end
        avl_waitrequest = 1'b0;
        for (int c = 3; c <= 10; c++) begin
            if (mem_ready) nrdy++;
            if (avl_write && avl_address == 32'h104) seen_b = 1'b1;
            if (avl_write && avl_address == 32'h108) seen_c = 1'b1;
            tick;
        end
        n_cmp++; if (nrdy !== 2 || seen_b !== 1'b1 || seen_c !== 1'b0) begin n_err++; $display("FAIL overrun_drop: got ready %0d b %b c %b want 2 1 0", nrdy, seen_b, seen_c); end
        n_cmp++; if (mem_overrun !== 1'b1) begin n_err++; $display("FAIL overrun_sticky: got %b want 1", mem_overrun); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (mem_overrun !== 1'b0) begin n_err++; $display("FAIL overrun_clear: got %b want 0", mem_overrun); end
        tick;
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_reset_mid;
        issue(1'b0, 30'h60, 32'h0);
        tick;
        mem_start = 1'b0;
        tick;
        issue(1'b1, 30'h61, 32'h77);
        tick;
        mem_start = 1'b0;
        issue(1'b0, 30'h63, 32'h0);
        tick;
        mem_start = 1'b0;
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({mem_ready, mem_fault, mem_overrun, avl_read, avl_write} !== 5'b0) begin n_err++; $display("FAIL rstmid_flags: got %b want 00000", {mem_ready, mem_fault, mem_overrun, avl_read, avl_write}); end
        n_cmp++; if (avl_address !== 32'h0 || avl_writedata !== 32'h0 || mem_data_rd !== 32'h0) begin n_err++; $display("FAIL rstmid_data: got %h/%h/%h want 0/0/0", avl_address, avl_writedata, mem_data_rd); end
        tick;
        rst_n = 1'b1;
        tick;
        issue(1'b1, 30'h62, 32'h99);
        tick;
        mem_start = 1'b0;
        n_cmp++; if (avl_write !== 1'b1 || avl_address !== 32'h188 || avl_writedata !== 32'h99) begin n_err++; $display("FAIL rstmid_next_cmd: got %b/%h/%h want 1/188/99", avl_write, avl_address, avl_writedata); end
        tick;
        n_cmp++; if (mem_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_next_ready: got %b want 1", mem_ready); end
        tick;
        tick;
        n_cmp++; if (avl_write !== 1'b0 || avl_read !== 1'b0 || avl_address !== 32'h188) begin n_err++; $display("FAIL rstmid_pending_lost: got %b%b/%h want 00/188", avl_write, avl_read, avl_address); end
    endtask

    initial begin
        test_reset;
        test_store;
        test_load_wait;
        test_pending;
        test_back_to_back;
`ifdef CORE_MEM_TIMEOUT_EN
        test_timeout;
`endif
        test_overrun;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1);
    end

endmodule

// File: doc/core_control_ldst_bus.md
# core_control_ldst_bus

Memory-side responder for the load/store control path. It accepts single-word requests issued by the core's load/store sequencer (`mem_start`/`mem_addr`/`mem_write`/`mem_data_wr`) and executes each one as an Avalon-MM pipelined master transaction. It returns completion to the sequencer as a one-cycle `mem_ready` pulse, with read data attached. It sits between the core control unit and the system interconnect, and provides a one-entry pending slot so back-to-back multi-register transfers do not stall on request/response turnaround.

## Interface
- `TIMEOUT_CYCLES`, 1024: bus cycles allowed per transaction before abort. Used only with `CORE_MEM_TIMEOUT_EN`.
- `clk` in 1: core clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `mem_start` in 1: one-cycle request strobe.
- `mem_addr` in 30 (`ptr`): word address.
- `mem_write` in 1: 1 = store, 0 = load. Sampled with `mem_start`.
- `mem_data_wr` in 32 (`word`): store data. Sampled with `mem_start`.
- `mem_ready` out 1: one-cycle completion pulse.
- `mem_data_rd` out 32 (`word`): load data. Valid when `mem_ready` pulses after a load; holds until the next load completes.
- `mem_fault` out 1: qualifies `mem_ready`; the transaction aborted on timeout.
- `mem_overrun` out 1: sticky; a request was dropped.
- `avl_address` out 32: byte address, `{addr, 2'b00}`.
- `avl_read`, `avl_write` out 1: command strobes.
- `avl_writedata` out 32: store data.
- `avl_byteenable` out 4: constant `4'b1111`.
- `avl_waitrequest` in 1: slave stall.
- `avl_readdata` in 32: read data.
- `avl_readdatavalid` in 1: read data valid.

## Operation
- FSM states: IDLE, CMD, RDATA.
- IDLE -> CMD:
  - on `mem_start`, the request is latched;
  - or, if the pending slot is valid, the pending request is promoted.
- CMD:
  - Holds `avl_read` or `avl_write` with stable address and data.
  - The command is accepted on the cycle the strobe is high and `avl_waitrequest` = 0.
  - An accepted write goes to IDLE and raises `mem_ready` next cycle.
  - An accepted read goes to RDATA.
- RDATA:
  - On `avl_readdatavalid`, `avl_readdata` is registered into `mem_data_rd` and `mem_ready` pulses next cycle.
  - FSM returns to IDLE.
- `mem_start` while not IDLE: captured into the pending slot (addr, write, data).
- `mem_start` while the pending slot is already full: the request is dropped and `mem_overrun` is set. `mem_overrun` clears only on reset.
- Pending has priority over a simultaneous `mem_start` in IDLE. That `mem_start` goes to pending, which is free in the same cycle.
- `mem_ready` is registered, so the FSM is already IDLE when it pulses. A `mem_start` in that cycle is a normal IDLE acceptance.
- `avl_readdatavalid` in IDLE or CMD with no stale read owed: ignored.

## Timing
- Reset values:
  - FSM in IDLE, pending slot empty;
  - `mem_ready`, `mem_fault`, `mem_overrun` = 0;
  - `avl_read`, `avl_write` = 0;
  - `avl_address`, `avl_writedata`, `mem_data_rd` = 0.
- Reset mid-transaction: strobes drop immediately (asynchronously) and the pending request is lost. The slave is not notified.
- Zero-wait write: `mem_start` at cycle 0, `avl_write` at 1, `mem_ready` at 2.
- Zero-wait read with readdatavalid one cycle after acceptance: `mem_start` at 0, `avl_read` at 1, readdatavalid at 2, `mem_ready` at 3.
- Each `avl_waitrequest` cycle adds one cycle. Each extra read-latency cycle adds one cycle.
- All outputs are registered; there is no combinational path from any input to any output.

## Configuration
- `CORE_MEM_TIMEOUT_EN` defined:
  - A cycle counter (`$clog2(TIMEOUT_CYCLES+1)` bits) clears on entry to CMD and counts in CMD and RDATA.
  - When it reaches `TIMEOUT_CYCLES`, the strobes drop, the FSM goes to IDLE, and `mem_ready` and `mem_fault` pulse together next cycle. `mem_data_rd` is unchanged.
  - A read aborted in RDATA sets a stale flag. The next `avl_readdatavalid` is discarded and clears the flag; it never completes a later read.
- `CORE_MEM_TIMEOUT_EN` undefined:
  - No counter and no stale flag; `mem_fault` is tied to 0.
  - The block waits indefinitely.

## Structure
- Types live in `core/uarch.sv`: `ptr`, `word`, and a new `ctrl_mem_state` enum (IDLE/CMD/RDATA).
- Add a `mem_req` struct (addr, write, data) for the latched and pending request.
- One sub-module, `core_control_ldst_bus_timeout`: a counter with clear, enable, and an `expired` output. It is instantiated only under `CORE_MEM_TIMEOUT_EN`.

## Test plan
- Store `mem_addr`=30'h100, data 32'hDEADBEEF, no waitrequest -> `avl_address`=32'h400 and `avl_write` high 1 cycle at cycle 1; `mem_ready` at cycle 2; `mem_fault`=0.
- Load 30'h4 with waitrequest high 3 cycles and readdata 32'h12345678 two cycles after acceptance -> `avl_read` held 4 cycles; `mem_data_rd`=32'h12345678 with `mem_ready`; the value holds through a following store.
- Start a load, then a store the cycle after while the load is still in CMD -> the store is pending; the load completes; `avl_write` asserts the cycle after the load's `mem_ready`; `mem_overrun` stays 0.
- Three `mem_start` pulses on consecutive cycles while busy -> the third is dropped; `mem_overrun`=1 until `rst_n` pulses low.
- With the macro defined and `TIMEOUT_CYCLES`=8, a read is never answered -> `mem_ready` and `mem_fault` at 8 cycles after CMD entry. A late readdatavalid carrying 32'hBAD is discarded, and the next load returns its own data.
- `rst_n` low mid-RDATA -> all outputs return to reset values at once; the next `mem_start` after reset completes normally.
